fetch_line_buffer: RTL and testbench
====================================

# fetch_line_buffer

Parametrised instruction-fetch front end. It requests one cache line over the shared system bus through the bus arbiter and collects the response beats into a line buffer. It then streams instructions one per handshake to decode, with PC tracking. It supports mid-line entry, sequential line advance, branch redirect with same-line hit, and redirect during an in-flight burst (drain-and-discard).

## Interface
Parameters:
- BUS_DATA_WIDTH, 64, width of one bus beat
- BUS_TAG_WIDTH, 13, bus tag width
- ADDRESS_WIDTH, 64, PC / address width
- INSTRUCTION_WIDTH, 32, instruction slot width
- LINE_BEATS, 8, beats per line; power of two, 2..16
- READ_TAG, 13'h1800, tag driven on line-read requests

Derived values:
- LINE_BYTES = LINE_BEATS*BUS_DATA_WIDTH/8
- SLOTS = LINE_BEATS*BUS_DATA_WIDTH/INSTRUCTION_WIDTH

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk  in  1  clock
  - reset  in  1  asynchronous active-high reset
- Start and redirect:
  - in_entry  in  ADDRESS_WIDTH  PC loaded at reset
  - in_redirect  in  1  branch redirect strobe
  - in_target  in  ADDRESS_WIDTH  redirect target, INSTRUCTION_WIDTH/8 aligned
- Decode side:
  - out_valid  out  1  instruction available
  - out_ready  in  1  decode accepts
  - out_instruction  out  INSTRUCTION_WIDTH  instruction bits
  - out_pc  out  ADDRESS_WIDTH  PC of out_instruction
- Arbiter:
  - abtr_reqcyc  out  1  arbitration request
  - abtr_grant  in  1  bus granted
  - bus_busy  out  1  bus owned, from grant through last beat or drain
- System bus:
  - bus_reqcyc  out  1  request valid
  - bus_req  out  BUS_DATA_WIDTH  line address, zero-extended
  - bus_reqtag  out  BUS_TAG_WIDTH  READ_TAG
  - bus_reqack  in  1  request accepted
  - bus_respcyc  in  1  response beat valid
  - bus_resp  in  BUS_DATA_WIDTH  response beat
  - bus_resptag  in  BUS_TAG_WIDTH  response tag, unused except for debug
  - bus_respack  out  1  beat acknowledge, combinational = bus_respcyc in FILL/DRAIN

## Operation
- Registers:
  - pc
  - line_addr = pc with low log2(LINE_BYTES) bits cleared
  - buf[LINE_BEATS*BUS_DATA_WIDTH]
  - buf_valid
  - beat counter (log2(LINE_BEATS)+1 bits)
  - pending_target
- States:
  - ARB: abtr_reqcyc=1; on abtr_grant -> REQ.
  - REQ: bus_reqcyc=1, bus_req=line_addr; held stable until bus_reqack -> FILL, counter=0.
  - FILL: each bus_respcyc writes beat `counter` into buf[counter*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] and increments the counter. After beat LINE_BEATS-1: buf_valid=1 -> SERVE.
  - SERVE: out_valid=1, out_instruction = slot pc[log2(LINE_BYTES)-1:log2(INSTRUCTION_WIDTH/8)] of buf, out_pc=pc. On transfer, pc += INSTRUCTION_WIDTH/8. If the transferred slot was SLOTS-1: buf_valid=0 -> ARB for the next line.
  - DRAIN: ack and discard the remaining beats of the aborted burst. After the last beat, pc=pending_target -> ARB.
- Redirect:
  - Has priority over a same-cycle transfer.
  - In SERVE: if target line == line_addr and buf_valid, pc=target and stay in SERVE (hit, no bus traffic). Otherwise buf_valid=0, pc=target -> ARB.
  - In ARB/REQ: pc=target. In REQ, bus_req updates only if bus_reqack has not yet been seen; a redirect in the reqack cycle -> FILL, then treated as below.
  - In FILL: pending_target=target -> DRAIN. The beat counter continues.
  - In DRAIN: pending_target overwritten with the newest target.
- bus_busy = 1 in REQ, FILL, DRAIN.

## Timing
- Reset values (asynchronous):
  - state=ARB, pc=in_entry, buf_valid=0, counter=0.
  - Outputs: out_valid=0, abtr_reqcyc=0 during reset, bus_reqcyc=0, bus_busy=0, bus_respack=0, out_instruction=0, out_pc=0.
- Reset mid-burst: the state machine returns to ARB immediately. Beats still arriving are not acked.
- Grant-to-request: bus_reqcyc asserts the cycle after abtr_grant is sampled.
- Miss latency: first out_valid is the cycle after the last beat is sampled.
- Same-line redirect hit: out_valid with the new pc the next cycle.
- SERVE sustains one instruction per cycle while out_ready=1. out_instruction/out_pc hold while out_valid && !out_ready.
- Back-to-back beats are accepted every cycle. Gaps in bus_respcyc are tolerated.

## Test plan
- Reset entry 0x1000, 8 beats data=beat index -> bus_req=0x1000, 16 instructions, out_pc 0x1000..0x103C, then bus_req=0x1040.
- Entry 0x1008 -> slots 2..15 only, 14 transfers (first out_pc=0x1008), then request 0x1040.
- Redirect to 0x1020 in SERVE at pc 0x1004 -> next cycle out_pc=0x1020, no abtr_reqcyc. Redirect to 0x2000 -> ARB, bus_req=0x2000.
- Redirect to 0x3000 after beat 3 of 8 -> remaining 4 beats acked, no out_valid during drain, then bus_req=0x3000.
- out_ready held low 5 cycles in SERVE -> out_instruction/out_pc stable, pc unchanged; redirect plus transfer in the same cycle -> redirect wins.
- Assert reset during FILL beat 2 -> all outputs at reset values asynchronously; after release, abtr_reqcyc=1 and bus_req=in_entry line.

Source files
------------

// File: rtl/fetch_line_buffer.sv
// Instruction fetch front end: fills one line over the shared bus, then streams one instruction per handshake.
// Bus request issues the cycle after grant. First out_valid comes the cycle after the last beat. Output holds while out_ready is low.
module fetch_line_buffer #(
    parameter int BUS_DATA_WIDTH    = 64,
    parameter int BUS_TAG_WIDTH     = 13,
    parameter int ADDRESS_WIDTH     = 64,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int LINE_BEATS        = 8,
    parameter logic [BUS_TAG_WIDTH-1:0] READ_TAG = 13'h1800
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDRESS_WIDTH-1:0]     in_entry,
    input  logic                         in_redirect,
    input  logic [ADDRESS_WIDTH-1:0]     in_target,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [INSTRUCTION_WIDTH-1:0] out_instruction,
    output logic [ADDRESS_WIDTH-1:0]     out_pc,
    output logic                         abtr_reqcyc,
    input  logic                         abtr_grant,
    output logic                         bus_busy,
    output logic                         bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0]    bus_req,
    output logic [BUS_TAG_WIDTH-1:0]     bus_reqtag,
    input  logic                         bus_reqack,
    input  logic                         bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0]    bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]     bus_resptag,
    output logic                         bus_respack
);
    localparam int LINE_W     = LINE_BEATS * BUS_DATA_WIDTH;
    localparam int LINE_BYTES = LINE_W / 8;
    localparam int SLOTS      = LINE_W / INSTRUCTION_WIDTH;
    localparam int LB         = $clog2(LINE_BYTES);
    localparam int IB         = $clog2(INSTRUCTION_WIDTH / 8);
    localparam int CW         = $clog2(LINE_BEATS) + 1;
    localparam int SW         = $clog2(SLOTS);

    localparam logic [ADDRESS_WIDTH-1:0] LINE_MASK = ~(ADDRESS_WIDTH'(LINE_BYTES - 1));
    localparam logic [ADDRESS_WIDTH-1:0] STEP      = ADDRESS_WIDTH'(INSTRUCTION_WIDTH / 8);
    localparam logic [CW-1:0]            LAST_BEAT = CW'(LINE_BEATS - 1);
    localparam logic [SW-1:0]            LAST_SLOT = SW'(SLOTS - 1);

    typedef enum logic [2:0] {ST_ARB, ST_REQ, ST_FILL, ST_SERVE, ST_DRAIN} state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [ADDRESS_WIDTH-1:0] pend_q, pend_d;
    logic [LINE_W-1:0]        line_q, line_d;
    logic                     buf_valid_q, buf_valid_d;
    logic [CW-1:0]            cnt_q, cnt_d;

    logic [ADDRESS_WIDTH-1:0]     line_addr;
    logic [ADDRESS_WIDTH-1:0]     target_line;
    logic [SW-1:0]                slot;
    logic                         last_beat;
    logic                         serving;
    logic [INSTRUCTION_WIDTH-1:0] slot_dat;
    logic                         unused_resptag;

    assign line_addr      = pc_q & LINE_MASK;
    assign target_line    = in_target & LINE_MASK;
    assign slot           = pc_q[LB-1:IB];
    assign last_beat      = bus_respcyc && (cnt_q == LAST_BEAT);
    assign serving        = (state_q == ST_SERVE);
    assign unused_resptag = ^bus_resptag;

    always_comb begin
        slot_dat = '0;
        for (int s = 0; s < SLOTS; s++) begin
            if (slot == SW'(s)) slot_dat = line_q[s*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH];
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        line_d      = line_q;
        buf_valid_d = buf_valid_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_ARB: begin
                if (in_redirect) pc_d = in_target;
                if (abtr_grant) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (bus_reqack) begin
                    cnt_d = '0;
                    // A redirect racing the accept leaves a whole burst to discard.
                    if (in_redirect) begin
                        pend_d  = in_target;
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else if (in_redirect) begin
                    pc_d = in_target;
                end
            end
            ST_FILL: begin
                if (bus_respcyc) cnt_d = cnt_q + CW'(1);
                if (in_redirect) begin
                    pend_d = in_target;
                    if (last_beat) begin
                        pc_d    = in_target;
                        state_d = ST_ARB;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (bus_respcyc) begin
                    for (int b = 0; b < LINE_BEATS; b++) begin
                        if (cnt_q == CW'(b)) line_d[b*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = bus_resp;
                    end
                    if (last_beat) begin
                        buf_valid_d = 1'b1;
                        state_d     = ST_SERVE;
                    end
                end
            end
            ST_SERVE: begin
                if (in_redirect) begin
                    pc_d = in_target;
                    if (!(buf_valid_q && target_line == line_addr)) begin
                        buf_valid_d = 1'b0;
                        state_d     = ST_ARB;
                    end
                end else if (out_ready) begin
                    pc_d = pc_q + STEP;
                    if (slot == LAST_SLOT) begin
                        buf_valid_d = 1'b0;
                        state_d     = ST_ARB;
                    end
                end
            end
            ST_DRAIN: begin
                if (in_redirect) pend_d = in_target;
                if (bus_respcyc) cnt_d = cnt_q + CW'(1);
                if (last_beat) begin
                    pc_d    = in_redirect ? in_target : pend_q;
                    state_d = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_ARB;
            pc_q        <= in_entry;
            pend_q      <= '0;
            line_q      <= '0;
            buf_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            line_q      <= line_d;
            buf_valid_q <= buf_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign abtr_reqcyc     = (state_q == ST_ARB) && !reset;
    assign bus_reqcyc      = (state_q == ST_REQ);
    assign bus_req         = BUS_DATA_WIDTH'(line_addr);
    assign bus_reqtag      = READ_TAG;
    assign bus_busy        = (state_q == ST_REQ) || (state_q == ST_FILL) || (state_q == ST_DRAIN);
    assign bus_respack     = bus_respcyc && ((state_q == ST_FILL) || (state_q == ST_DRAIN));
    assign out_valid       = serving;
    assign out_instruction = serving ? slot_dat : '0;
    assign out_pc          = serving ? pc_q : '0;

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Bench for fetch_line_buffer: directed line-fetch vectors, redirect/drain/reset sequences, then random traffic vs. a PC-stream model.
module tb_fetch_line_buffer;
    localparam int NBEATS = 8;

    logic        clk, reset;
    logic [63:0] in_entry, in_target;
    logic        in_redirect;
    logic        out_valid, out_ready;
    logic [31:0] out_instruction;
    logic [63:0] out_pc;
    logic        abtr_reqcyc, abtr_grant, bus_busy;
    logic        bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
    logic [63:0] bus_req, bus_resp;
    logic [12:0] bus_reqtag, bus_resptag;

    fetch_line_buffer dut (
        .clk(clk), .reset(reset), .in_entry(in_entry),
        .in_redirect(in_redirect), .in_target(in_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction(out_instruction), .out_pc(out_pc),
        .abtr_reqcyc(abtr_reqcyc), .abtr_grant(abtr_grant), .bus_busy(bus_busy),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
        .bus_resptag(bus_resptag), .bus_respack(bus_respack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks, n_err;
    int          p_grant, p_ack, p_beat;
    bit          idx_mode;
    bit          redir_now, ready_now;
    logic [63:0] redir_tgt;
    logic [63:0] exp_pc, burst_line;
    int          beats_left, beat_idx, xfers;

    typedef struct {
        logic [63:0] entry;
        logic [63:0] first_req;
        logic [63:0] first_pc;
        int          n_xfer;
        logic [63:0] next_req;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] line_of(input logic [63:0] a);
        return a & ~64'h3F;
    endfunction

    // Memory image as the bus returns it, beat by beat.
    function automatic logic [63:0] beat_data(input logic [63:0] l, input int k);
        if (idx_mode) return 64'(k);
        return {(l[31:0] + 32'(8*k + 4)) ^ 32'h5A5A_0000, l[31:0] + 32'(8*k)};
    endfunction

    // Same memory image, viewed as the instruction stored at a byte address.
    function automatic logic [31:0] exp_instr(input logic [63:0] a);
        if (idx_mode) return a[2] ? 32'h0 : {29'h0, a[5:3]};
        return a[2] ? (a[31:0] ^ 32'h5A5A_0000) : a[31:0];
    endfunction

    task automatic step();
        @(negedge clk);
        abtr_grant  = abtr_reqcyc && ($urandom_range(0, 99) < p_grant);
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        bus_resp    = '0;
        if (bus_reqcyc) begin
            bus_reqack = ($urandom_range(0, 99) < p_ack);
        end else if (beats_left > 0 && ($urandom_range(0, 99) < p_beat)) begin
            bus_respcyc = 1'b1;
            bus_resp    = beat_data(burst_line, beat_idx);
        end
        in_redirect = redir_now;
        in_target   = redir_tgt;
        out_ready   = ready_now;
        #1;
        if (out_valid) begin
            check("out_pc", out_pc, exp_pc);
            check("out_instruction", 64'(out_instruction), 64'(exp_instr(exp_pc)));
        end
        if (bus_reqack && !in_redirect) check("bus_req", bus_req, line_of(exp_pc));
        if (bus_respcyc) check("bus_respack", 64'(bus_respack), 64'd1);
        if (bus_reqack) begin
            beats_left = NBEATS;
            beat_idx   = 0;
            burst_line = bus_req;
        end
        if (bus_respcyc) begin
            beat_idx++;
            beats_left--;
        end
        if (in_redirect) exp_pc = in_target;
        else if (out_valid && out_ready) begin
            exp_pc = exp_pc + 64'd4;
            xfers++;
        end
    endtask

    task automatic do_reset(input logic [63:0] entry);
        @(negedge clk);
        in_entry    = entry;
        abtr_grant  = 1'b0;
        bus_reqack  = 1'b0;
        in_redirect = 1'b0;
        out_ready   = 1'b0;
        bus_respcyc = 1'b1;
        reset       = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_abtr_reqcyc", 64'(abtr_reqcyc), 64'd0);
        check("rst_bus_reqcyc", 64'(bus_reqcyc), 64'd0);
        check("rst_bus_busy", 64'(bus_busy), 64'd0);
        check("rst_bus_respack", 64'(bus_respack), 64'd0);
        check("rst_out_instruction", 64'(out_instruction), 64'd0);
        check("rst_out_pc", out_pc, 64'd0);
        repeat (2) @(negedge clk);
        bus_respcyc = 1'b0;
        reset       = 1'b0;
        beats_left  = 0;
        beat_idx    = 0;
        exp_pc      = entry;
        redir_now   = 1'b0;
    endtask

    initial begin
        int first_req_c, first_val_c, n, acks;
        bit done;
        n_checks = 0; n_err = 0; xfers = 0;
        reset = 1'b0; in_entry = 64'h1000; in_redirect = 1'b0; in_target = '0;
        out_ready = 1'b0; abtr_grant = 1'b0; bus_reqack = 1'b0; bus_respcyc = 1'b0;
        bus_resp = '0; bus_resptag = 13'h1800;
        redir_now = 1'b0; ready_now = 1'b0; redir_tgt = '0;
        exp_pc = '0; burst_line = '0; beats_left = 0; beat_idx = 0;
        p_grant = 100; p_ack = 100; p_beat = 100; idx_mode = 1'b1;

        vecs[0] = '{64'h1000, 64'h1000, 64'h1000, 16, 64'h1040};
        vecs[1] = '{64'h1008, 64'h1000, 64'h1008, 14, 64'h1040};
        vecs[2] = '{64'h103C, 64'h1000, 64'h103C,  1, 64'h1040};
        vecs[3] = '{64'h2FF0, 64'h2FC0, 64'h2FF0,  4, 64'h3000};

        for (int v = 0; v < 4; v++) begin
            do_reset(vecs[v].entry);
            ready_now = 1'b1;
            first_req_c = -1; first_val_c = -1; n = 0; done = 1'b0;
            for (int c = 0; c < 200 && !done; c++) begin
                step();
                if (bus_reqcyc && first_req_c < 0) begin
                    first_req_c = c;
                    check("vec_first_req", bus_req, vecs[v].first_req);
                end
                if (out_valid) begin
                    if (first_val_c < 0) begin
                        first_val_c = c;
                        check("vec_first_pc", out_pc, vecs[v].first_pc);
                    end
                    n++;
                end else if (first_val_c >= 0 && bus_reqcyc) begin
                    done = 1'b1;
                    check("vec_next_req", bus_req, vecs[v].next_req);
                end
            end
            check("vec_done", 64'(done), 64'd1);
            check("vec_grant_to_req", 64'(first_req_c), 64'd1);
            check("vec_miss_latency", 64'(first_val_c), 64'(2 + NBEATS));
            check("vec_xfer_count", 64'(n), 64'(vecs[v].n_xfer));
        end

        // Same-line redirect hit, then a missing redirect, stall, and redirect-over-transfer.
        do_reset(64'h1000);
        ready_now = 1'b0;
        for (int k = 0; k < 100 && !out_valid; k++) step();
        check("hit_first_pc", out_pc, 64'h1000);
        ready_now = 1'b1; step();
        ready_now = 1'b0; redir_now = 1'b1; redir_tgt = 64'h1020; step();
        redir_now = 1'b0; step();
        check("hit_valid", 64'(out_valid), 64'd1);
        check("hit_pc", out_pc, 64'h1020);
        check("hit_no_arb", 64'(abtr_reqcyc), 64'd0);
        redir_now = 1'b1; redir_tgt = 64'h2000; step();
        redir_now = 1'b0; step();
        check("miss_arb", 64'(abtr_reqcyc), 64'd1);
        check("miss_no_valid", 64'(out_valid), 64'd0);
        for (int k = 0; k < 100 && !bus_reqcyc; k++) step();
        check("miss_req", bus_req, 64'h2000);
        for (int k = 0; k < 100 && !out_valid; k++) step();
        for (int k = 0; k < 5; k++) begin
            step();
            check("stall_pc", out_pc, 64'h2000);
            check("stall_instr", 64'(out_instruction), 64'(exp_instr(64'h2000)));
        end
        redir_now = 1'b1; redir_tgt = 64'h2008; ready_now = 1'b1; step();
        redir_now = 1'b0; ready_now = 1'b0; step();
        check("redir_beats_xfer", out_pc, 64'h2008);

        // Redirect after beat 3 of a burst: the rest must be drained.
        redir_now = 1'b1; redir_tgt = 64'h5000; step();
        redir_now = 1'b0;
        for (int k = 0; k < 100 && !(beats_left == 4 && beat_idx == 4); k++) step();
        check("pre_drain_beats", 64'(beat_idx), 64'd4);
        p_beat = 0; redir_now = 1'b1; redir_tgt = 64'h3000; step();
        p_beat = 100; redir_now = 1'b0; acks = 0;
        for (int k = 0; k < 50 && beats_left > 0; k++) begin
            step();
            if (bus_respcyc && bus_respack) acks++;
            check("drain_no_valid", 64'(out_valid), 64'd0);
            check("drain_busy", 64'(bus_busy), 64'd1);
        end
        check("drain_acks", 64'(acks), 64'd4);
        for (int k = 0; k < 100 && !bus_reqcyc; k++) step();
        check("drain_next_req", bus_req, 64'h3000);
        for (int k = 0; k < 100 && !out_valid; k++) step();
        check("drain_first_pc", out_pc, 64'h3000);

        // Reset asserted while beat 2 of a fill is on the bus.
        do_reset(64'h1000);
        for (int k = 0; k < 100 && !(beat_idx == 2 && beats_left == NBEATS - 2); k++) step();
        check("pre_reset_beats", 64'(beat_idx), 64'd2);
        do_reset(64'h7010);
        step();
        check("post_reset_arb", 64'(abtr_reqcyc), 64'd1);
        check("post_reset_req", bus_req, 64'h7000);
        check("post_reset_busy", 64'(bus_busy), 64'd0);

        // Random traffic against the PC-stream model.
        idx_mode = 1'b0; p_grant = 60; p_ack = 50; p_beat = 70;
        do_reset(64'h4000);
        xfers = 0;
        for (int i = 0; i < 4000; i++) begin
            ready_now = ($urandom_range(0, 99) < 75);
            redir_now = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 1) == 1)
                redir_tgt = line_of(exp_pc) + (64'($urandom_range(0, 15)) << 2);
            else
                redir_tgt = 64'h4000 + (64'($urandom_range(0, 31)) << 6) + (64'($urandom_range(0, 15)) << 2);
            step();
        end
        check("rand_progress", 64'(xfers > 300), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
